// File: rtl/uart_fifo_dev.sv
// Byte-wide 8N1 UART device with TX and RX FIFOs on the CPU bus.
// di/do_ready feed the CPU jump-condition logic; data_out is the RX head.
module uart_fifo_dev #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic [7:0] data_in,
  input  logic       _wr,
  input  logic       _rd,
  output logic [7:0] data_out,
  output logic       di,
  output logic       do_ready,
  output logic       tx,
  input  logic       rx,
  output logic       rx_overflow,
  output logic       tx_overflow,
  output logic       framing_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TXF = 0;
  localparam int RXF = 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [1:0]      push, pop, empty, full, drop;
  logic [1:0][7:0] wdata, head;

  // Index 0 is the TX FIFO, index 1 the RX FIFO.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [FIFO_DEPTH];
      logic [PW-1:0] wptr_reg, rptr_reg;
      logic          do_push, do_pop;

      assign empty[gi] = (wptr_reg == rptr_reg);
      assign full[gi]  = (wptr_reg[AW] != rptr_reg[AW]) &&
                         (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);
      assign do_pop    = pop[gi] && !empty[gi];
      // A pop on the same edge frees the slot the push lands in.
      assign do_push   = push[gi] && (!full[gi] || do_pop);
      assign drop[gi]  = push[gi] && full[gi] && !do_pop;
      assign head[gi]  = mem[rptr_reg[AW-1:0]];

      always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
          wptr_reg <= '0;
          rptr_reg <= '0;
        end else begin
          if (do_push) wptr_reg <= wptr_reg + PW'(1);
          if (do_pop)  rptr_reg <= rptr_reg + PW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (do_push) mem[wptr_reg[AW-1:0]] <= wdata[gi];
      end
    end
  endgenerate

  // ---------------- TX serializer ----------------
  state_t        tx_state_reg, tx_state_next;
  logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
  logic [2:0]    tx_bit_reg, tx_bit_next;
  logic [7:0]    tx_shift_reg, tx_shift_next;
  logic          tx_reg, tx_next;
  logic          tx_pop;
  logic          tx_overflow_reg;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      tx_state_reg    <= S_IDLE;
      tx_cnt_reg      <= '0;
      tx_bit_reg      <= '0;
      tx_shift_reg    <= '0;
      tx_reg          <= 1'b1;
      tx_overflow_reg <= 1'b0;
    end else begin
      tx_state_reg    <= tx_state_next;
      tx_cnt_reg      <= tx_cnt_next;
      tx_bit_reg      <= tx_bit_next;
      tx_shift_reg    <= tx_shift_next;
      tx_reg          <= tx_next;
      tx_overflow_reg <= tx_overflow_reg | drop[TXF];
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_next       = tx_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      S_IDLE: begin
        tx_next = 1'b1;
        if (!empty[TXF]) begin
          tx_pop        = 1'b1;
          tx_shift_next = head[TXF];
          tx_cnt_next   = '0;
          tx_state_next = S_START;
          tx_next       = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = S_DATA;
          tx_next       = tx_shift_reg[0];
        end else begin
          tx_cnt_next = tx_cnt_reg + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == 3'd7) begin
            tx_state_next = S_STOP;
            tx_next       = 1'b1;
          end else begin
            tx_bit_next   = tx_bit_reg + 3'd1;
            tx_shift_next = {1'b0, tx_shift_reg[7:1]};
            tx_next       = tx_shift_reg[1];
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CW'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next = '0;
          // Back-to-back frames: queued data starts the next frame with no idle gap.
          if (!empty[TXF]) begin
            tx_pop        = 1'b1;
            tx_shift_next = head[TXF];
            tx_state_next = S_START;
            tx_next       = 1'b0;
          end else begin
            tx_state_next = S_IDLE;
            tx_next       = 1'b1;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CW'(1);
        end
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  // ---------------- RX deserializer ----------------
  state_t        rx_state_reg, rx_state_next;
  logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next;
  logic          rx_wait_high_reg, rx_wait_high_next;
  logic          framing_err_reg, framing_err_next;
  logic          rx_overflow_reg;
  logic          rx_meta_reg, rxs_reg;
  logic          rx_push;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rx_meta_reg      <= 1'b1;
      rxs_reg          <= 1'b1;
      rx_state_reg     <= S_IDLE;
      rx_cnt_reg       <= '0;
      rx_bit_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_wait_high_reg <= 1'b0;
      framing_err_reg  <= 1'b0;
      rx_overflow_reg  <= 1'b0;
    end else begin
      rx_meta_reg      <= rx;
      rxs_reg          <= rx_meta_reg;
      rx_state_reg     <= rx_state_next;
      rx_cnt_reg       <= rx_cnt_next;
      rx_bit_reg       <= rx_bit_next;
      rx_shift_reg     <= rx_shift_next;
      rx_wait_high_reg <= rx_wait_high_next;
      framing_err_reg  <= framing_err_next;
      rx_overflow_reg  <= rx_overflow_reg | drop[RXF];
    end
  end

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_cnt_next       = rx_cnt_reg;
    rx_bit_next       = rx_bit_reg;
    rx_shift_next     = rx_shift_reg;
    rx_wait_high_next = rx_wait_high_reg;
    framing_err_next  = framing_err_reg;
    rx_push           = 1'b0;
    case (rx_state_reg)
      S_IDLE: begin
        // After a framing error the line must return high before re-arming.
        if (rx_wait_high_reg) begin
          if (rxs_reg) rx_wait_high_next = 1'b0;
        end else if (!rxs_reg) begin
          rx_cnt_next   = '0;
          rx_state_next = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rxs_reg ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rxs_reg, rx_shift_reg[7:1]};
          if (rx_bit_reg == 3'd7) rx_state_next = S_STOP;
          else                    rx_bit_next   = rx_bit_reg + 3'd1;
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = S_IDLE;
          if (rxs_reg) begin
            rx_push = 1'b1;
          end else begin
            framing_err_next  = 1'b1;
            rx_wait_high_next = 1'b1;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + CW'(1);
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  assign push[TXF]  = !_wr;
  assign wdata[TXF] = data_in;
  assign pop[TXF]   = tx_pop;
  assign push[RXF]  = rx_push;
  assign wdata[RXF] = rx_shift_reg;
  assign pop[RXF]   = !_rd;

  assign data_out    = empty[RXF] ? 8'h00 : head[RXF];
  assign di          = !empty[RXF];
  assign do_ready    = !full[TXF];
  assign tx          = tx_reg;
  assign rx_overflow = rx_overflow_reg;
  assign tx_overflow = tx_overflow_reg;
  assign framing_err = framing_err_reg;

endmodule

// File: tb/tb_uart_fifo_dev.sv
// Randomized bench for uart_fifo_dev: a serial-line monitor decodes tx, a
// bit-banged driver feeds rx, and queues model the FIFO contents and flags.
module tb_uart_fifo_dev;
  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       _reset, _wr, _rd, rx, rx_drv, loop;
  logic [7:0] data_in, data_out;
  logic       di, do_ready, tx, rx_overflow, tx_overflow, framing_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];
  logic [8:0] tx_seen[$];
  logic [7:0] tx_acc[$];
  logic       exp_rxovf = 1'b0, exp_txovf = 1'b0, exp_ferr = 1'b0;

  uart_fifo_dev #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), ._reset(_reset), .data_in(data_in), ._wr(_wr), ._rd(_rd),
    .data_out(data_out), .di(di), .do_ready(do_ready), .tx(tx), .rx(rx),
    .rx_overflow(rx_overflow), .tx_overflow(tx_overflow), .framing_err(framing_err)
  );

  assign rx = loop ? tx : rx_drv;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic check_rx(input string tag);
    check({tag, ".di"}, di, rx_q.size() > 0);
    check({tag, ".data_out"}, data_out, rx_q.size() > 0 ? rx_q[0] : 8'h00);
    check({tag, ".framing_err"}, framing_err, exp_ferr);
    check({tag, ".rx_overflow"}, rx_overflow, exp_rxovf);
    check({tag, ".tx_overflow"}, tx_overflow, exp_txovf);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    int f = pos / C;
    if (f == 0) return 1'b0;
    if (f <= 8) return b[f-1];
    return 1'b1;
  endfunction

  // Decodes every frame seen on tx by mid-bit sampling: {stop, data}.
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0) begin
      logic [7:0] b;
      repeat (C + C/2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        b[k] = tx;
        repeat (C) @(negedge clk);
      end
      tx_seen.push_back({tx, b});
    end
  end

  task automatic cpu_write(input logic [7:0] b);
    data_in = b;
    _wr = 1'b0;
    @(negedge clk);
    _wr = 1'b1;
  endtask

  task automatic cpu_read();
    _rd = 1'b0;
    @(negedge clk);
    _rd = 1'b1;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
  endtask

  // Drives one 8N1 frame on rx; optionally pops RX on the edge that samples the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic rd_same);
    rx_drv = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (C) @(negedge clk);
    end
    rx_drv = stop_bit;
    repeat (C) @(negedge clk);
    rx_drv = 1'b1;
    if (rd_same) begin
      _rd = 1'b0;
      @(negedge clk);
      _rd = 1'b1;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (!stop_bit)             exp_ferr = 1'b1;
    else if (rx_q.size() < D)  rx_q.push_back(b);
    else                       exp_rxovf = 1'b1;
    repeat (2*C + $urandom_range(0, 5)) @(negedge clk);
  endtask

  task automatic check_tx_seen(input string tag);
    check({tag, ".count"}, tx_seen.size(), tx_acc.size());
    for (int i = 0; i < tx_acc.size() && i < tx_seen.size(); i++)
      check($sformatf("%s.byte%0d", tag, i), tx_seen[i], {1'b1, tx_acc[i]});
    tx_seen.delete();
    tx_acc.delete();
  endtask

  initial begin
    logic [7:0] b2, r;
    int         cnt;
    logic       ser_idle, pop_now;

    _reset = 1'b1; _wr = 1'b1; _rd = 1'b1; data_in = 8'h00; rx_drv = 1'b1; loop = 1'b0;
    #1 _reset = 1'b0;
    #1 check("rst.tx", tx, 1'b1);
    repeat (3) @(negedge clk);
    _reset = 1'b1;
    @(negedge clk);
    check("rst.do_ready", do_ready, 1'b1);
    check("rst.tx_after", tx, 1'b1);
    check_rx("rst");

    // Exact waveform of A5 followed by a queued byte with no gap.
    b2 = 8'($urandom);
    data_in = 8'hA5; _wr = 1'b0;
    @(negedge clk);
    data_in = b2;
    check("wave.idle_at_N", tx, 1'b1);
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (i == 1) _wr = 1'b1;
      check($sformatf("wave[%0d]", i), tx,
            i <= 40 ? exp_bit(8'hA5, i - 1) : (i <= 80 ? exp_bit(b2, i - 41) : 1'b1));
    end
    tx_acc.push_back(8'hA5);
    tx_acc.push_back(b2);
    check_tx_seen("wave_mon");

    // Back-to-back writes: serializer takes the first, FIFO holds D, rest overflow.
    cnt = 0; ser_idle = 1'b1;
    for (int k = 0; k < 6; k++) begin
      r = 8'($urandom);
      data_in = r; _wr = 1'b0;
      @(negedge clk);
      pop_now = ser_idle && cnt > 0;
      if (pop_now) begin cnt--; ser_idle = 1'b0; end
      if (cnt < D) begin cnt++; tx_acc.push_back(r); end
      else exp_txovf = 1'b1;
      check($sformatf("fill%0d.do_ready", k), do_ready, cnt < D);
      check($sformatf("fill%0d.tx_overflow", k), tx_overflow, exp_txovf);
    end
    _wr = 1'b1;
    repeat (6*10*C + 20) @(negedge clk);
    check("fill.do_ready_drained", do_ready, 1'b1);
    check_tx_seen("fill_mon");

    // RX: glitch, good frame, framing error, fill, simultaneous push/pop, overflow.
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check_rx("glitch");
    send_frame(8'($urandom), 1'b1, 1'b0); check_rx("rx_good0");
    send_frame(8'($urandom), 1'b0, 1'b0); check_rx("rx_framing");
    for (int k = 1; k < D; k++) begin
      send_frame(8'($urandom), 1'b1, 1'b0);
      check_rx($sformatf("rx_good%0d", k));
    end
    send_frame(8'($urandom), 1'b1, 1'b1); check_rx("rx_push_pop_full");
    send_frame(8'($urandom), 1'b1, 1'b0); check_rx("rx_overflow");
    for (int k = 0; k < D; k++) begin
      cpu_read();
      check_rx($sformatf("rx_pop%0d", k));
    end
    cpu_read();
    check_rx("rx_pop_empty");

    // Loopback tx -> rx.
    loop = 1'b1;
    @(negedge clk);
    foreach (b2[i]) ;
    for (int k = 0; k < 3; k++) begin
      r = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'h3C;
      cpu_write(r);
      tx_acc.push_back(r);
      rx_q.push_back(r);
      repeat (10*C + 10) @(negedge clk);
      check_rx($sformatf("loop_frame%0d", k));
    end
    for (int k = 0; k < 3; k++) begin
      cpu_read();
      check_rx($sformatf("loop_pop%0d", k));
    end
    check_tx_seen("loop_mon");

    // Reset in the middle of a start bit with bytes queued and all flags set.
    cpu_write(8'($urandom));
    cpu_write(8'($urandom));
    cpu_write(8'($urandom));
    check("midrst.tx_low", tx, 1'b0);
    #2 _reset = 1'b0;
    #1 check("midrst.tx_immediate", tx, 1'b1);
    rx_q.delete();
    exp_rxovf = 1'b0; exp_txovf = 1'b0; exp_ferr = 1'b0;
    check_rx("midrst.held");
    @(negedge clk);
    _reset = 1'b1;
    @(negedge clk);
    check("midrst.do_ready", do_ready, 1'b1);
    check_rx("midrst.released");
    repeat (10*C + 20) @(negedge clk);
    tx_seen.delete();
    repeat (10*C + 20) @(negedge clk);
    check("midrst.no_frames", tx_seen.size(), 0);
    check_rx("midrst.quiet");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
